clk_enable_scheduler: RTL and testbench
=======================================

Name: clk_enable_scheduler

Overview:
Multi-channel programmable divider controller that replaces per-consumer fixed divider instances. It owns one counter per channel and generates one-cycle tick enables plus 50%-duty divided square waves (idle-high) for the sample, FFT and display consumers. Divisors and enables are written at runtime through a valid/ready config port. Writes to running channels are shadowed and applied only at the period boundary, so outputs never glitch.

Parameters:
NUM_CH, 4, number of independent divider channels (1..16)
DIV_W, 16, width of each channel divisor and counter
DEFAULT_DIV, 1, reset value of every channel's active divisor
CH_W (localparam), max(1, clog2(NUM_CH)), width of cfg_ch

Ports:
clk_in  input  1  system clock; all logic is on the rising edge
rst_n  input  1  asynchronous, active-low reset
cfg_valid  input  1  config write request
cfg_ready  output  1  config write accepted when cfg_valid && cfg_ready
cfg_ch  input  CH_W  target channel
cfg_div  input  DIV_W  divisor; period = cfg_div+1 cycles
cfg_en  input  1  channel enable written with the divisor
sync_start  input  1  one-cycle pulse; phase-aligns all enabled channels
tick  output  NUM_CH  per-channel one-cycle enable pulse, registered
clk_out  output  NUM_CH  per-channel divided square wave, registered, idle 1
pending  output  NUM_CH  shadow divisor waiting for the next boundary

Behaviour:
- Reset (async assert, sync-released use): cnt=0, div_act=DEFAULT_DIV, en=0, div_sh=0, pending=0, tick=0, clk_out=all 1.
- cfg_ready is combinational: !pending[cfg_ch]. It is 1 when cfg_ch >= NUM_CH; that write is accepted and ignored.
- Accepted write, channel disabled, cfg_en=1:
  - div_act<=cfg_div, cnt<=0, clk_out<=1, en<=1.
  - First tick is high in the cycle following edge cfg_div+1 after the accept edge.
- Accepted write, channel disabled, cfg_en=0: div_act<=cfg_div. No other change.
- Accepted write, channel enabled, cfg_en=1: div_sh<=cfg_div, pending<=1. Counting continues unchanged.
- Accepted write, channel enabled, cfg_en=0 (disable):
  - Takes effect immediately: en<=0, cnt<=0, clk_out<=1, tick<=0, pending<=0, div_act<=cfg_div.
- Enabled channel, each edge:
  - If cnt==div_act: wrap. cnt<=0, tick<=1, clk_out toggles. If pending: div_act<=div_sh, pending<=0.
  - Otherwise: cnt<=cnt+1, tick<=0.
  - Tick period = div_act+1 cycles. clk_out period = 2*(div_act+1).
  - div_act=0 gives tick held high and clk_out toggling every cycle.
- Disabled channel: cnt held at 0, tick=0, clk_out=1.
- sync_start, every enabled channel on the same edge:
  - cnt<=0, clk_out<=1, tick<=0.
  - A pending shadow is applied: div_act<=div_sh, pending<=0.
  - No tick is produced on the sync edge, even if cnt==div_act.
- Same-edge priorities:
  - Config write to channel c and sync_start on the same edge: the write wins for channel c. A write with cfg_en=1 to an enabled channel loads div_act directly (sync is a boundary), pending stays 0, cnt<=0, clk_out<=1. Other channels take sync.
  - Wrap and sync_start on the same edge: sync wins.
- Counter is compared with equality only. cnt never exceeds div_act because div_act changes only when cnt is reset to 0.
- Reset mid-period: all state returns to reset values immediately, with no partial tick.

Test Plan:
1. Reset, DEFAULT_DIV=1: hold rst_n=0 then release -> clk_out=4'b1111, tick=0, pending=0, cfg_ready=1; no ticks for 20 cycles.
2. Write ch0 div=4 en=1 -> tick[0] pulses every 5 cycles, first 5 cycles after accept; clk_out[0] falls at first tick, period 10.
3. With ch0 running div=4, write div=1 at cnt=2 -> pending[0]=1. A second ch0 write stalls (cfg_ready=0) until the wrap. That wrap keeps period 5; following ticks every 2 cycles; pending clears at the wrap.
4. Write ch1 div=0 en=1 -> tick[1] constant 1, clk_out[1] toggles each cycle. Write ch1 en=0 div=7 -> next cycle tick[1]=0, clk_out[1]=1.
5. ch0 div=2 and ch2 div=5 running out of phase; pulse sync_start -> both clk_out=1 next cycle. Ticks at +3 and +6 for ch0, +6 for ch2; coincide every 6 cycles.
6. Assert rst_n=0 mid-period with pending[0]=1 -> outputs return to reset values without waiting for clk_in; after release, ch0 is disabled and div_act=DEFAULT_DIV.

Source files
------------

// File: rtl/clk_enable_scheduler.sv
// clk_enable_scheduler: multi-channel programmable divider.
// Each channel has its own counter. It produces a registered one-cycle tick
// at every period boundary and a 50%-duty square wave that idles high.
// A write to a running channel is held in a shadow register and is applied
// only at the next boundary (a wrap or sync_start), so the outputs never glitch.
module clk_enable_scheduler #(
   parameter  int NUM_CH      = 4,
   parameter  int DIV_W       = 16,
   parameter  int DEFAULT_DIV = 1,
   localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              clk_in,
   input  logic              rst_n,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   input  logic [CH_W-1:0]   cfg_ch,
   input  logic [DIV_W-1:0]  cfg_div,
   input  logic              cfg_en,
   input  logic              sync_start,
   output logic [NUM_CH-1:0] tick,
   output logic [NUM_CH-1:0] clk_out,
   output logic [NUM_CH-1:0] pending
);

   logic [DIV_W-1:0]  cnt     [NUM_CH];
   logic [DIV_W-1:0]  div_act [NUM_CH];
   logic [DIV_W-1:0]  div_sh  [NUM_CH];
   logic [NUM_CH-1:0] en;
   logic [NUM_CH-1:0] wr_hit;

   // Ready is low only while the addressed channel already holds a shadow value.
   // A channel number with no channel behind it matches nothing, so ready stays 1
   // and the write is accepted and dropped.
   always_comb begin
      // NOTE: assigning a default before any condition means no path leaves the
      // output unassigned, so no latch is inferred.
      cfg_ready = 1'b1;
      for (int i = 0; i < NUM_CH; i++) begin
         if (cfg_ch == CH_W'(i)) cfg_ready = !pending[i];
      end
   end

   // One-hot decode of the accepted config write.
   always_comb begin
      wr_hit = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         wr_hit[i] = cfg_valid && cfg_ready && (cfg_ch == CH_W'(i));
      end
   end

   // Per-channel counting, boundary handling and config writes.
   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: the per-channel arrays are small flop banks, not RAM. They are
         // reset here so that every channel leaves reset with a known divisor.
         for (int i = 0; i < NUM_CH; i++) begin
            cnt[i]     <= '0;
            div_act[i] <= DIV_W'(DEFAULT_DIV);
            div_sh[i]  <= '0;
         end
         en      <= '0;
         pending <= '0;
         tick    <= '0;
         clk_out <= '1;
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            // Baseline behaviour when this channel has no write on this edge.
            // NOTE: all state uses non-blocking assignments. When a later
            // assignment in this block targets the same bit, it overrides the
            // baseline, and that override is how a write takes priority.
            if (en[i]) begin
               if (sync_start) begin
                  // Sync is a boundary. It never produces a tick, even when cnt==div_act.
                  cnt[i]     <= '0;
                  clk_out[i] <= 1'b1;
                  tick[i]    <= 1'b0;
                  if (pending[i]) begin
                     div_act[i] <= div_sh[i];
                     pending[i] <= 1'b0;
                  end
               end else if (cnt[i] == div_act[i]) begin
                  cnt[i]     <= '0;
                  tick[i]    <= 1'b1;
                  clk_out[i] <= ~clk_out[i];
                  if (pending[i]) begin
                     div_act[i] <= div_sh[i];
                     pending[i] <= 1'b0;
                  end
               end else begin
                  cnt[i]  <= cnt[i] + DIV_W'(1);
                  tick[i] <= 1'b0;
               end
            end else begin
               cnt[i]     <= '0;
               tick[i]    <= 1'b0;
               clk_out[i] <= 1'b1;
            end

            // An accepted write to this channel wins over sync for this channel.
            if (wr_hit[i]) begin
               if (!en[i]) begin
                  // Idle channel: load the divisor directly. If enabled, start
                  // counting from cnt=0 with the output high (baseline above).
                  div_act[i] <= cfg_div;
                  if (cfg_en) en[i] <= 1'b1;
               end else if (!cfg_en) begin
                  // Disable takes effect at once.
                  en[i]      <= 1'b0;
                  cnt[i]     <= '0;
                  clk_out[i] <= 1'b1;
                  tick[i]    <= 1'b0;
                  pending[i] <= 1'b0;
                  div_act[i] <= cfg_div;
               end else if (sync_start) begin
                  // Sync is itself a boundary, so the new divisor goes live now.
                  div_act[i] <= cfg_div;
                  pending[i] <= 1'b0;
                  cnt[i]     <= '0;
                  clk_out[i] <= 1'b1;
                  tick[i]    <= 1'b0;
               end else begin
                  // Running channel: shadow the divisor until the next wrap.
                  div_sh[i]  <= cfg_div;
                  pending[i] <= 1'b1;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_clk_enable_scheduler.sv
// Testbench for clk_enable_scheduler.
// Directed scenarios followed by random config/sync traffic. The reference
// model describes each channel by the edge on which its current period started,
// the output level at that start, and the divisor. Tick and square-wave values
// are then derived from the elapsed edge count by division and modulo.
module tb_clk_enable_scheduler;

   localparam int NUM_CH      = 4;
   localparam int DIV_W       = 16;
   localparam int DEFAULT_DIV = 1;
   localparam int CH_W        = 2;

   logic              clk_in     = 1'b0;
   logic              rst_n      = 1'b0;
   logic              cfg_valid  = 1'b0;
   logic              cfg_en     = 1'b0;
   logic              sync_start = 1'b0;
   logic [CH_W-1:0]   cfg_ch     = '0;
   logic [DIV_W-1:0]  cfg_div    = '0;
   logic              cfg_ready;
   logic [NUM_CH-1:0] tick;
   logic [NUM_CH-1:0] clk_out;
   logic [NUM_CH-1:0] pending;

   int checks = 0;
   int errors = 0;

   // Reference model state.
   int t;
   int m_start [NUM_CH];
   int m_div   [NUM_CH];
   int m_sh    [NUM_CH];
   bit m_en    [NUM_CH];
   bit m_pend  [NUM_CH];
   bit m_lvl   [NUM_CH];
   logic [NUM_CH-1:0] e_tick;
   logic [NUM_CH-1:0] e_clk;
   logic [NUM_CH-1:0] e_pend;

   clk_enable_scheduler #(
      .NUM_CH(NUM_CH), .DIV_W(DIV_W), .DEFAULT_DIV(DEFAULT_DIV)
   ) dut (
      .clk_in(clk_in), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
      .cfg_ch(cfg_ch), .cfg_div(cfg_div), .cfg_en(cfg_en), .sync_start(sync_start),
      .tick(tick), .clk_out(clk_out), .pending(pending)
   );

   always #5 clk_in = ~clk_in;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h (t=%0d)", tag, got, exp, t);
      end
   endtask

   function automatic void model_reset();
      t = 0;
      for (int i = 0; i < NUM_CH; i++) begin
         m_start[i] = 0; m_div[i] = DEFAULT_DIV; m_sh[i] = 0;
         m_en[i] = 0; m_pend[i] = 0; m_lvl[i] = 1;
      end
      e_tick = '0; e_clk = '1; e_pend = '0;
   endfunction

   function automatic bit m_ready(input int ch);
      return (ch >= NUM_CH) ? 1'b1 : !m_pend[ch];
   endfunction

   // Advance the model by one rising edge, given what was presented before it.
   function automatic void model_edge(input bit acc, input int ch, input int dv,
                                      input bit e, input bit s);
      t++;
      for (int i = 0; i < NUM_CH; i++) begin
         bit hit    = acc && (ch == i);
         bit rebase = 0;
         int p, el;
         if (hit && (!m_en[i] || !e || s)) begin
            m_div[i] = dv;
            if (m_en[i] || e) begin
               m_en[i] = e; m_pend[i] = 0; m_start[i] = t; m_lvl[i] = 1;
            end
         end else if (m_en[i]) begin
            if (s) begin
               if (m_pend[i]) begin m_div[i] = m_sh[i]; m_pend[i] = 0; end
               m_start[i] = t; m_lvl[i] = 1;
            end else begin
               p  = m_div[i] + 1;
               el = t - m_start[i];
               if (el > 0 && el % p == 0 && m_pend[i]) begin
                  m_lvl[i]   = m_lvl[i] ^ bit'((el / p) & 1);
                  m_start[i] = t; m_div[i] = m_sh[i]; m_pend[i] = 0;
                  rebase = 1;
               end
            end
            if (hit) begin m_sh[i] = dv; m_pend[i] = 1; end
         end
         if (!m_en[i]) begin
            e_tick[i] = 0; e_clk[i] = 1;
         end else if (rebase) begin
            e_tick[i] = 1; e_clk[i] = m_lvl[i];
         end else begin
            p  = m_div[i] + 1;
            el = t - m_start[i];
            e_tick[i] = (el > 0) && (el % p == 0);
            e_clk[i]  = m_lvl[i] ^ bit'((el / p) & 1);
         end
         e_pend[i] = m_pend[i];
      end
   endfunction

   // One clock cycle: drive, check ready, clock, update model, check outputs.
   task automatic step(input bit v, input int ch, input int dv, input bit e, input bit s);
      bit rdy;
      @(negedge clk_in);
      cfg_valid = v; cfg_ch = CH_W'(ch); cfg_div = DIV_W'(dv); cfg_en = e; sync_start = s;
      #1;
      rdy = m_ready(ch);
      check("cfg_ready", {31'd0, cfg_ready}, {31'd0, rdy});
      @(posedge clk_in);
      model_edge(v && rdy, ch, dv, e, s);
      #1;
      check("tick", {28'd0, tick}, {28'd0, e_tick});
      check("clk_out", {28'd0, clk_out}, {28'd0, e_clk});
      check("pending", {28'd0, pending}, {28'd0, e_pend});
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0);
   endtask

   initial begin
      int lat;
      model_reset();

      // Reset state while rst_n is low, then no activity after release.
      #12;
      check("rst_tick", {28'd0, tick}, 32'h0);
      check("rst_clk_out", {28'd0, clk_out}, 32'hF);
      check("rst_pending", {28'd0, pending}, 32'h0);
      check("rst_ready", {31'd0, cfg_ready}, 32'h1);
      @(negedge clk_in);
      rst_n = 1'b1;
      idle(20);

      // ch0 div=4: first tick five edges after the accept edge.
      step(1, 0, 4, 1, 0);
      lat = 0;
      for (int k = 1; k <= 20; k++) begin
         step(0, 0, 0, 0, 0);
         if (tick[0] === 1'b1) begin lat = k; break; end
      end
      check("first_tick_latency", lat, 5);
      check("clk_out0_falls_at_tick", {31'd0, clk_out[0]}, 32'h0);
      idle(12);

      // Shadowed write: div=1 while running, then a second write stalls.
      idle(2);
      step(1, 0, 1, 1, 0);
      check("pending_set", {31'd0, pending[0]}, 32'h1);
      step(1, 0, 3, 1, 0);
      step(1, 0, 3, 1, 0);
      step(0, 0, 0, 0, 0);
      idle(10);

      // ch1 div=0: tick held high, then immediate disable.
      step(1, 1, 0, 1, 0);
      idle(5);
      step(1, 1, 7, 0, 0);
      check("ch1_off_tick", {31'd0, tick[1]}, 32'h0);
      check("ch1_off_clk", {31'd0, clk_out[1]}, 32'h1);
      idle(2);

      // ch0 div=2 and ch2 div=5 out of phase, then sync.
      step(1, 0, 0, 0, 0);
      step(1, 0, 2, 1, 0);
      idle(2);
      step(1, 2, 5, 1, 0);
      idle(7);
      step(0, 0, 0, 0, 1);
      check("sync_clk0", {31'd0, clk_out[0]}, 32'h1);
      check("sync_clk2", {31'd0, clk_out[2]}, 32'h1);
      idle(14);

      // Async reset mid-period with a pending shadow.
      step(1, 0, 4, 1, 1);
      idle(1);
      step(1, 0, 1, 1, 0);
      @(negedge clk_in);
      cfg_valid = 0; sync_start = 0;
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_tick", {28'd0, tick}, 32'h0);
      check("async_rst_clk", {28'd0, clk_out}, 32'hF);
      check("async_rst_pending", {28'd0, pending}, 32'h0);
      model_reset();
      repeat (2) @(negedge clk_in);
      rst_n = 1'b1;
      idle(12);

      // Random traffic.
      for (int k = 0; k < 3000; k++) begin
         step(bit'($urandom_range(0, 1)), int'($urandom_range(0, NUM_CH - 1)),
              int'($urandom_range(0, 6)), ($urandom_range(0, 4) != 0),
              ($urandom_range(0, 29) == 0));
      end
      idle(4);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
